// File: rtl/multiples_fetch_sequencer_pkg.sv
// Shared constants for the multiples fetch sequencer: word geometry, memory size
// and FSM state encodings.
package multiples_fetch_sequencer_pkg;

  localparam int unsigned NO_OF_ROW_BY_VECTOR_MODULES = 4;
  localparam int unsigned WORD_W                      = 32 * NO_OF_ROW_BY_VECTOR_MODULES;
  localparam int unsigned MEM_DEPTH                   = 100001;
  localparam int unsigned COUNT_W                     = 17;
  localparam int unsigned ADDR_W                      = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/multiples_fetch_sequencer_if.sv
// Downstream word stream (valid/ready) from the fetch sequencer to the
// row-by-vector array.
interface multiples_fetch_sequencer_if
  import multiples_fetch_sequencer_pkg::*;
#(
  parameter int unsigned word_w = WORD_W
) ();

  logic [word_w-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/multiples_skid_fifo.sv
// Two-entry FIFO with a registered head; simultaneous push and pop are both
// honoured in every occupancy, including full.
module multiples_skid_fifo #(
  parameter int unsigned width = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [width-1:0] head_q;
  logic [width-1:0] tail_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_nxt_c;

  assign cnt_nxt_c = cnt_q + 2'(push) - 2'(pop);
  assign dout      = head_q;

  // Head only changes on a pop or when a push lands in an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      cnt_q <= cnt_nxt_c;
      full  <= (cnt_nxt_c == 2'd2);
      empty <= (cnt_nxt_c == 2'd0);
      if (pop) begin
        if (cnt_q == 2'd2) begin
          head_q <= tail_q;
          if (push) tail_q <= din;
        end else if (push) begin
          head_q <= din;
        end
      end else if (push) begin
        if (cnt_q == 2'd0) head_q <= din;
        else               tail_q <= din;
      end
    end
  end

endmodule

// File: rtl/multiples_fetch_sequencer.sv
// Streams a contiguous run of multiples words from memory into the
// row-by-vector array through a two-entry buffer.
module multiples_fetch_sequencer
  import multiples_fetch_sequencer_pkg::*;
#(
  parameter int unsigned no_of_row_by_vector_modules = NO_OF_ROW_BY_VECTOR_MODULES,
  parameter int unsigned mem_depth                   = MEM_DEPTH,
  parameter int unsigned count_width                 = COUNT_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [ADDR_W-1:0]                         base_address,
  input  logic [count_width-1:0]                    word_count,
  output logic [ADDR_W-1:0]                         multiples_read_address,
  input  logic [32*no_of_row_by_vector_modules-1:0] multiples_output,
  multiples_fetch_sequencer_if.master               out_if,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      range_error
);

  localparam int unsigned word_w = 32 * no_of_row_by_vector_modules;

  logic [1:0]             state_q;
  logic [1:0]             state_nxt;
  logic [ADDR_W-1:0]      addr_nxt;
  logic [count_width-1:0] rem_q;
  logic [count_width-1:0] rem_nxt;
  logic                   done_nxt;
  logic                   rerr_nxt;
  logic                   push_c;
  logic                   pop_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W:0]        end_addr_c;

  assign end_addr_c       = {1'b0, base_address} + (ADDR_W+1)'(word_count);
  assign pop_c            = !fifo_empty && out_if.out_ready;
  assign out_if.out_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                <= ST_IDLE;
      multiples_read_address <= '0;
      rem_q                  <= '0;
      done                   <= 1'b0;
      range_error            <= 1'b0;
      busy                   <= 1'b0;
    end else begin
      state_q                <= state_nxt;
      multiples_read_address <= addr_nxt;
      rem_q                  <= rem_nxt;
      done                   <= done_nxt;
      range_error            <= rerr_nxt;
      busy                   <= (state_nxt != ST_IDLE);
    end
  end

  // A read is consumed whenever the buffer has room this cycle, counting a same-cycle pop.
  always_comb begin
    state_nxt = state_q;
    addr_nxt  = multiples_read_address;
    rem_nxt   = rem_q;
    done_nxt  = 1'b0;
    rerr_nxt  = 1'b0;
    push_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (end_addr_c > (ADDR_W+1)'(mem_depth)) begin
            rerr_nxt = 1'b1;
          end else if (word_count == '0) begin
            done_nxt = 1'b1;
          end else begin
            addr_nxt  = base_address;
            rem_nxt   = word_count;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (!fifo_full || pop_c) begin
          push_c   = 1'b1;
          addr_nxt = multiples_read_address + ADDR_W'(1);
          rem_nxt  = rem_q - count_width'(1);
          if (rem_q == count_width'(1)) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // No pushes here, so a pop while not full empties the buffer.
        if (pop_c && !fifo_full) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  multiples_skid_fifo #(
    .width (word_w)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (multiples_output),
    .dout  (out_if.out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
